// File: rtl/byte_striping_n_if.sv
// Handshake and lane bus for the N-lane byte striper.
// With BYTE_STRIPING_PARITY_EN defined the bus also carries per-lane even parity.
interface byte_striping_n_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int PTR_W  = $clog2(LANES)
);
    logic                      valid_in;
    logic [DATA_W-1:0]         data_in;
    logic                      in_ready;
    logic                      flush;
    logic [PTR_W-1:0]          start_lane;
    logic [LANES*DATA_W-1:0]   lane_data;
    logic [LANES-1:0]          lane_valid;
    logic                      out_valid;
    logic                      out_ready;
    logic [PTR_W-1:0]          lane_ptr;
`ifdef BYTE_STRIPING_PARITY_EN
    logic [LANES-1:0]          lane_parity;
`endif

    modport slave (
        input  valid_in, data_in, flush, start_lane, out_ready,
        output in_ready, lane_data, lane_valid, out_valid, lane_ptr
`ifdef BYTE_STRIPING_PARITY_EN
        , output lane_parity
`endif
    );

    modport master (
        output valid_in, data_in, flush, start_lane, out_ready,
        input  in_ready, lane_data, lane_valid, out_valid, lane_ptr
`ifdef BYTE_STRIPING_PARITY_EN
        , input lane_parity
`endif
    );
endinterface

// File: rtl/byte_striping_n.sv
// Round-robin striper: serial DATA_W words into LANES lanes via a staging buffer and output register.
// Optional per-lane parity output under macro BYTE_STRIPING_PARITY_EN.
module byte_striping_n #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
) (
    input  logic             clk_f,
    input  logic             reset,
    byte_striping_n_if.slave bus
);
    localparam int PTR_W = $clog2(LANES);
    localparam int CNT_W = $clog2(LANES + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(LANES);
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);
    localparam logic [PTR_W:0]   LANES_EXT = (PTR_W + 1)'(LANES);

    logic [LANES-1:0][DATA_W-1:0] stage_data_q, stage_data_d;
    logic [LANES-1:0][DATA_W-1:0] out_data_q, out_data_d;
    logic [LANES-1:0][DATA_W-1:0] masked;
    logic [LANES-1:0]             fill_q, fill_d;
    logic [LANES-1:0]             out_lv_q, out_lv_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic [PTR_W-1:0]             start_eff;
    logic                         pend_q, pend_d;
    logic                         out_valid_q, out_valid_d;
    logic                         in_ready;
    logic                         accept;
    logic                         xfer;

    // A closed group waits in staging; only a held output register can stall new input.
    assign in_ready  = !reset && !(pend_q && out_valid_q);
    assign accept    = bus.valid_in && in_ready;
    assign xfer      = pend_q && (!out_valid_q || bus.out_ready);
    assign start_eff = ({1'b0, bus.start_lane} < LANES_EXT) ? bus.start_lane : '0;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            masked[k] = fill_q[k] ? stage_data_q[k] : '0;
        end
    end

    always_comb begin
        stage_data_d = stage_data_q;
        fill_d       = xfer ? '0 : fill_q;
        cnt_d        = xfer ? '0 : cnt_q;
        pend_d       = pend_q && !xfer;
        ptr_d        = ptr_q;

        if (accept) begin
            stage_data_d[ptr_q] = bus.data_in;
            fill_d[ptr_q]       = 1'b1;
            cnt_d               = cnt_d + 1'b1;
            if (cnt_d == FULL_CNT) begin
                pend_d = 1'b1;
                ptr_d  = start_eff;
            end else begin
                ptr_d = (ptr_q == LAST_LANE) ? '0 : ptr_q + 1'b1;
            end
        end

        // Flush closes whatever is staged, including a word accepted this same cycle.
        if (bus.flush && !pend_d && (cnt_d != '0)) begin
            pend_d = 1'b1;
            ptr_d  = start_eff;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_lv_d    = out_lv_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = masked;
            out_lv_d    = fill_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_data_d  = '0;
            out_lv_d    = '0;
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_f) begin
        if (reset) begin
            fill_q      <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_lv_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_lv_q    <= out_lv_d;
            out_valid_q <= out_valid_d;
        end
    end

    // NOTE: staging data needs no reset; fill bits gate it, so only they are cleared.
    always_ff @(posedge clk_f) begin
        stage_data_q <= stage_data_d;
    end

`ifdef BYTE_STRIPING_PARITY_EN
    logic [LANES-1:0] out_par_q, out_par_d;

    always_comb begin
        out_par_d = out_par_q;
        if (xfer) begin
            for (int k = 0; k < LANES; k++) begin
                out_par_d[k] = ^masked[k];
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_par_d = '0;
        end
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            out_par_q <= '0;
        end else begin
            out_par_q <= out_par_d;
        end
    end

    assign bus.lane_parity = out_par_q;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.lane_data  = out_data_q;
    assign bus.lane_valid = out_lv_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.lane_ptr   = ptr_q;
endmodule

// File: tb/tb_byte_striping_n.sv
// Directed plus random bench for byte_striping_n with a group-level scoreboard model.
// Parity outputs are checked when BYTE_STRIPING_PARITY_EN is defined.
module tb_byte_striping_n;
    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int PTR_W  = $clog2(LANES);
    localparam int BUS_W  = LANES * DATA_W;

    typedef struct {
        logic [BUS_W-1:0] data;
        logic [LANES-1:0] lv;
    } grp_t;

    logic clk_f;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    byte_striping_n_if #(.DATA_W(DATA_W), .LANES(LANES)) bus();

    byte_striping_n #(.DATA_W(DATA_W), .LANES(LANES)) dut (
        .clk_f (clk_f),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    // Reference model: words land in lanes, groups queue up in close order.
    logic [DATA_W-1:0] m_data [LANES];
    logic [LANES-1:0]  m_fill;
    int                m_cnt;
    int                m_ptr;
    grp_t              exp_q [$];
    logic              last_acc;

    logic              hold_prev;
    logic [BUS_W-1:0]  p_data;
    logic [LANES-1:0]  p_lv;
`ifdef BYTE_STRIPING_PARITY_EN
    logic [LANES-1:0]  p_par;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < LANES; k++) m_data[k] = '0;
        m_fill = '0;
        m_cnt  = 0;
    endtask

    task automatic close_group(input int st);
        grp_t g;
        for (int k = 0; k < LANES; k++) begin
            g.data[k*DATA_W +: DATA_W] = m_fill[k] ? m_data[k] : '0;
        end
        g.lv = m_fill;
        exp_q.push_back(g);
        model_clear();
        m_ptr = (st < LANES) ? st : 0;
    endtask

    task automatic tick();
        logic s_acc, s_hs, s_rst, s_flush;
        int   s_start;
        logic [DATA_W-1:0] s_din;
        grp_t g;
        @(negedge clk_f);
        s_acc   = bus.valid_in && bus.in_ready;
        s_hs    = bus.out_valid && bus.out_ready;
        s_rst   = reset;
        s_flush = bus.flush;
        s_start = int'(bus.start_lane);
        s_din   = bus.data_in;

        if (hold_prev) begin
            check("hold_valid", 64'(bus.out_valid), 64'(1'b1));
            check("hold_data", 64'(bus.lane_data), 64'(p_data));
            check("hold_lv", 64'(bus.lane_valid), 64'(p_lv));
`ifdef BYTE_STRIPING_PARITY_EN
            check("hold_par", 64'(bus.lane_parity), 64'(p_par));
`endif
        end
        hold_prev = bus.out_valid && !bus.out_ready && !reset;
        p_data    = bus.lane_data;
        p_lv      = bus.lane_valid;
`ifdef BYTE_STRIPING_PARITY_EN
        p_par     = bus.lane_parity;
`endif

        if (s_hs && !s_rst) begin
            check("grp_expected", 64'(exp_q.size() > 0), 64'(1'b1));
            if (exp_q.size() > 0) begin
                g = exp_q.pop_front();
                check("grp_data", 64'(bus.lane_data), 64'(g.data));
                check("grp_lv", 64'(bus.lane_valid), 64'(g.lv));
`ifdef BYTE_STRIPING_PARITY_EN
                for (int k = 0; k < LANES; k++) begin
                    check("grp_par", 64'(bus.lane_parity[k]), 64'(^g.data[k*DATA_W +: DATA_W]));
                end
`endif
            end
        end

        @(posedge clk_f);
        #1;
        if (s_rst) begin
            model_clear();
            m_ptr = 0;
            exp_q.delete();
        end else begin
            if (s_acc) begin
                m_data[m_ptr] = s_din;
                m_fill[m_ptr] = 1'b1;
                m_cnt++;
                if (m_cnt == LANES) close_group(s_start);
                else m_ptr = (m_ptr + 1) % LANES;
            end
            if (s_flush && m_cnt > 0) close_group(s_start);
        end
        last_acc = s_acc;
        check("lane_ptr", 64'(bus.lane_ptr), 64'(m_ptr));
    endtask

    task automatic idle(input int n);
        bus.valid_in = 1'b0;
        bus.flush    = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic fl);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.flush    = fl;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) break;
        end
        check("send_accepted", 64'(last_acc), 64'(1'b1));
        bus.valid_in = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [LANES-1:0] lv,
                             input logic [BUS_W-1:0] d);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(ov));
        check({tag, "_lv"}, 64'(bus.lane_valid), 64'(lv));
        check({tag, "_data"}, 64'(bus.lane_data), 64'(d));
    endtask

    initial begin
        model_clear();
        m_ptr          = 0;
        last_acc       = 1'b0;
        hold_prev      = 1'b0;
        reset          = 1'b1;
        bus.valid_in   = 1'b0;
        bus.data_in    = '0;
        bus.flush      = 1'b0;
        bus.start_lane = '0;
        bus.out_ready  = 1'b1;

        // Reset behaviour
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'(1'b0));
        tick();
        check_out("rst", 1'b0, '0, '0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1'b1));

        // Nominal group
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b0);
        send_word(8'h44, 1'b0);
        check("nom_latency", 64'(bus.out_valid), 64'(1'b0));
        tick();
        check_out("nom", 1'b1, 4'b1111, 32'h44332211);
        tick();

        // Gapped input, with start lane 2 taking effect at this group's close
        bus.start_lane = PTR_W'(2);
        send_word(8'hA0, 1'b0);
        check("gap_a0", 64'(bus.out_valid), 64'(1'b0));
        idle(2);
        check("gap_idle", 64'(bus.out_valid), 64'(1'b0));
        send_word(8'hA1, 1'b0);
        send_word(8'hA2, 1'b0);
        idle(1);
        check("gap_a2", 64'(bus.out_valid), 64'(1'b0));
        send_word(8'hA3, 1'b0);
        check("gap_a3", 64'(bus.out_valid), 64'(1'b0));
        tick();
        check_out("gap", 1'b1, 4'b1111, 32'hA3A2A1A0);

        // Start lane 2
        for (int i = 1; i <= 4; i++) send_word(8'(i), 1'b0);
        tick();
        check_out("start", 1'b1, 4'b1111, 32'h02010403);
        bus.start_lane = '0;
        for (int i = 0; i < 4; i++) send_word(8'(8'h90 + i), 1'b0);
        idle(2);
        check("realign_ptr", 64'(bus.lane_ptr), 64'(0));

        // Flush partial, then flush on empty staging
        idle(1);
        send_word(8'h5A, 1'b0);
        send_word(8'h5B, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        check_out("flush", 1'b1, 4'b0011, 32'h00005B5A);
        idle(2);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        check("flush_empty_a", 64'(bus.out_valid), 64'(1'b0));
        tick();
        check("flush_empty_b", 64'(bus.out_valid), 64'(1'b0));

        // Backpressure: two groups, the second stalls in staging
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_word(8'(8'h80 + i), 1'b0);
        check("bp_in_ready", 64'(bus.in_ready), 64'(1'b0));
        check_out("bp_hold", 1'b1, 4'b1111, 32'h83828180);
        idle(3);
        check("bp_in_ready_hold", 64'(bus.in_ready), 64'(1'b0));
        bus.out_ready = 1'b1;
        tick();
        check_out("bp_second", 1'b1, 4'b1111, 32'h87868584);
        check("bp_in_ready_back", 64'(bus.in_ready), 64'(1'b1));
        tick();
        tick();
        check("bp_drained", 64'(bus.out_valid), 64'(1'b0));

        // Reset mid-group
        send_word(8'hC0, 1'b0);
        send_word(8'hC1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_out("midrst", 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) send_word(8'(8'hD0 + i), 1'b0);
        tick();
        check_out("post_midrst", 1'b1, 4'b1111, 32'hD3D2D1D0);
        idle(2);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 99) == 0);
            bus.valid_in   = ($urandom_range(0, 1) == 1);
            bus.data_in    = 8'($urandom);
            bus.flush      = ($urandom_range(0, 9) == 0);
            bus.out_ready  = ($urandom_range(0, 9) < 7);
            bus.start_lane = PTR_W'($urandom);
            tick();
        end
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        idle(12);
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/byte_striping_n.md
Name: byte_striping_n

Overview:
- Parametrised successor to the two-lane byte striper.
- Distributes a serial stream of DATA_W-bit words round-robin across LANES parallel output lanes, on a single clock.
- Adds a ready/valid handshake on both sides, a flush for partial groups, and a start-lane selection.
- Sits between the serial source and the per-lane transmit logic. Its output feeds the matching N-lane un-striper.

Parameters:
- DATA_W, 8, width of each input word and each lane.
- LANES, 4, number of output lanes; legal range 2..16.
- PTR_W, $clog2(LANES), width of the lane pointer (derived; do not override).

Ports:
- clk_f, input, 1, sole clock; all logic on its rising edge.
- reset, input, 1, synchronous, active-high.
- valid_in, input, 1, data_in holds a word this cycle.
- data_in, input, DATA_W, input word.
- in_ready, output, 1, block accepts a word this cycle.
- flush, input, 1, close the current partial group.
- start_lane, input, PTR_W, lane that receives the first word of each group; sampled only when the pointer is at group start.
- lane_data, output, LANES*DATA_W, lane k occupies bits [k*DATA_W +: DATA_W].
- lane_valid, output, LANES, per-lane valid for the presented group.
- out_valid, output, 1, a group is presented on lane_data.
- out_ready, input, 1, downstream accepts the presented group.
- lane_ptr, output, PTR_W, lane that receives the next accepted word (debug/visibility).

Behaviour:
- Reset (sync, active-high): lane_data=0, lane_valid=0, out_valid=0, lane_ptr=0, staging buffer empty, in_ready=0 during the reset cycle. in_ready=1 on the first cycle after reset deasserts.
- Input accept condition: valid_in && in_ready. The word is written to staging slot lane_ptr, and the slot's fill bit is set.
- Pointer advance: lane_ptr advances modulo LANES on each accept.
  - A group closes when the number of words written equals LANES.
  - On close, lane_ptr reloads from start_lane.
  - valid_in low: pointer and staging hold (gaps tolerated).
- start_lane ≥ LANES is illegal and is treated as 0.
- Two register stages: staging buffer, then output register.
- Group close: staging is copied to the output register on the clock after the closing word.
  - out_valid=1, all lane_valid bits=1.
  - Latency: 1 cycle from acceptance of the last word to out_valid.
- Output hold: lane_data, lane_valid and out_valid are stable while out_valid && !out_ready. They clear one cycle after a cycle with out_valid && out_ready, unless a new group transfers in that same edge.
- Backpressure: in_ready=0 only when staging is complete (or flushed) and the output register holds an unaccepted group.
  - If out_ready=1 in that cycle, the transfer occurs and in_ready returns to 1 next cycle.
  - No word is ever dropped or duplicated.
- Flush:
  - With ≥1 filled slot: close the group as-is. The output carries lane_valid = fill bits, and unfilled lanes carry 0.
  - With an empty staging buffer: no effect (no empty group is emitted).
  - flush with an accepted valid_in in the same cycle: the word is included in the flushed group.
  - Pointer reloads from start_lane after a flush.
- Simultaneous close and output accept: the old group retires and the new group loads on the same edge. out_valid stays 1 with no bubble.
- Reset mid-group or mid-hold: partial staging and any held output are discarded; no output is produced for them.

Optional Feature:
- Macro: BYTE_STRIPING_PARITY_EN.
- Defined: adds output lane_parity [LANES]. Bit k is the even parity (XOR reduction) of lane k's data, registered with lane_data.
  - Forced 0 when lane_valid[k]=0.
  - Reset value 0.
  - Held under backpressure with the data.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Nominal (LANES=4, start_lane=0, out_ready=1): words 0x11,0x22,0x33,0x44 on consecutive cycles → one cycle after 0x44, out_valid=1, lane_valid=4'b1111, lanes 0..3 = 0x11,0x22,0x33,0x44; lane_ptr back to 0.
- Gapped input: 0xA0, idle, idle, 0xA1, 0xA2, idle, 0xA3 → a single group, lanes 0..3 = A0,A1,A2,A3; no out_valid before A3 is accepted.
- Start lane: start_lane=2, words 0x01..0x04 → lane2=0x01, lane3=0x02, lane0=0x03, lane1=0x04, all lane_valid=1.
- Flush partial: 0x5A, 0x5B, then flush with no valid_in → lane_valid=4'b0011, lanes 0/1 = 5A/5B, lanes 2/3 = 0; flush on empty staging → no out_valid.
- Backpressure: hold out_ready=0, stream 8 words 0x80..0x87 → first group held stable; in_ready drops after 0x87 is accepted; raise out_ready → groups 80..83 then 84..87 emitted in order, no loss or repetition.
- Reset mid-group: accept 0xC0, 0xC1, assert reset for one cycle → all outputs 0, lane_ptr=0; next 4 words form a clean group with no C0/C1 present.
